// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
//
// Hardware return-address stack for the stack-based call/return scheme.
// The control unit marks a JAL (push of PC+4) with MemWrite=1 and
// MemtoReg=2'b10. It marks a JS (pop, jump to top) with MemRead=1 and
// Jump=2'b10. The top entry is presented combinationally, so the JS target
// is available in the same cycle as the decode.
//
// Ports:
//   Clock      in   1       system clock, rising edge
//   Reset      in   1       synchronous, active-low
//   Stall      in   1       1 = hold all state, requests ignored
//   Jump       in   2       control unit; 2'b10 marks JS
//   MemtoReg   in   2       control unit; 2'b10 marks JAL
//   MemWrite   in   1       control unit
//   MemRead    in   1       control unit
//   PushAddr   in   AW      return address to push
//   TopAddr    out  AW      current top entry (0 when empty)
//   Empty      out  1       Count == 0
//   Full       out  1       Count == DEPTH
//   Count      out  PW+1    number of valid entries
//   Fault      out  1       sticky error indicator
//   Overflow   out  1       sticky, push attempted while full
//   Underflow  out  1       sticky, pop attempted while empty
//
// Optional build macro RAS_WRAP_OVERFLOW_EN:
//   When defined, a push while full overwrites the oldest entry. Overflow is
//   still flagged, but Fault is not raised and the stack keeps running.
//   When undefined, a push while full freezes the stack in the fault state.
// -----------------------------------------------------------------------------
module return_addr_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int PW    = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Stall,
  input  logic [1:0]    Jump,
  input  logic [1:0]    MemtoReg,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [AW-1:0] PushAddr,
  output logic [AW-1:0] TopAddr,
  output logic          Empty,
  output logic          Full,
  output logic [PW:0]   Count,
  output logic          Fault,
  output logic          Overflow,
  output logic          Underflow
);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FAULT  = 1'b1
  } state_t;

  localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] SP_ONE    = PW'(1);

  // Entry storage; deliberately not cleared by reset.
  logic [AW-1:0] mem [DEPTH];

  state_t        state_reg, state_next;
  logic [PW-1:0] sp_reg, sp_next;
  logic [PW:0]   count_reg, count_next;
  logic          fault_reg, fault_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;

  logic          mem_we;
  logic [PW-1:0] mem_waddr;
  logic [AW-1:0] mem_wdata;

  logic          push_req, pop_req;
  logic          empty_w, full_w;
  logic [PW-1:0] sp_top;

  assign push_req = MemWrite & (MemtoReg == 2'b10) & ~Stall;
  assign pop_req  = MemRead  & (Jump     == 2'b10) & ~Stall;

  assign empty_w  = (count_reg == '0);
  assign full_w   = (count_reg == DEPTH_CNT);
  // sp points at the next free slot, so the top lives one below (mod DEPTH).
  assign sp_top   = sp_reg - SP_ONE;

  // Next-state / write-port logic.
  always_comb begin
    state_next     = state_reg;
    sp_next        = sp_reg;
    count_next     = count_reg;
    fault_next     = fault_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    mem_we         = 1'b0;
    mem_waddr      = sp_reg;
    mem_wdata      = PushAddr;

    case (state_reg)
      ST_NORMAL: begin
        if (push_req && pop_req) begin
          if (!empty_w) begin
            // Simultaneous push/pop collapses to a replace of the top entry.
            mem_we    = 1'b1;
            mem_waddr = sp_top;
          end else begin
            // Nothing to pop: behaves as a plain push, no underflow.
            mem_we     = 1'b1;
            sp_next    = sp_reg + SP_ONE;
            count_next = count_reg + CNT_ONE;
          end
        end else if (push_req) begin
          if (full_w) begin
`ifdef RAS_WRAP_OVERFLOW_EN
            // When full, sp equals the oldest slot, so writing there
            // discards the oldest entry while count stays at DEPTH.
            mem_we        = 1'b1;
            sp_next       = sp_reg + SP_ONE;
            overflow_next = 1'b1;
`else
            overflow_next = 1'b1;
            fault_next    = 1'b1;
            state_next    = ST_FAULT;
`endif
          end else begin
            mem_we     = 1'b1;
            sp_next    = sp_reg + SP_ONE;
            count_next = count_reg + CNT_ONE;
          end
        end else if (pop_req) begin
          if (empty_w) begin
            underflow_next = 1'b1;
            fault_next     = 1'b1;
            state_next     = ST_FAULT;
          end else begin
            sp_next    = sp_top;
            count_next = count_reg - CNT_ONE;
          end
        end
      end
      ST_FAULT: begin
        // Frozen until reset.
      end
      default: state_next = ST_FAULT;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg     <= ST_NORMAL;
      sp_reg        <= '0;
      count_reg     <= '0;
      fault_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sp_reg        <= sp_next;
      count_reg     <= count_next;
      fault_reg     <= fault_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage write; reset takes priority over any request in the same cycle.
  always_ff @(posedge Clock) begin
    if (Reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Combinational top read so the JS target costs no extra cycle.
  assign TopAddr   = empty_w ? '0 : mem[sp_top];
  assign Empty     = empty_w;
  assign Full      = full_w;
  assign Count     = count_reg;
  assign Fault     = fault_reg;
  assign Overflow  = overflow_reg;
  assign Underflow = underflow_reg;

endmodule

// File: tb/tb_return_addr_stack.sv
// -----------------------------------------------------------------------------
// tb_return_addr_stack
//
// Directed stimulus for return_addr_stack. A queue-based model of the stack
// is advanced on each rising edge and checked against every DUT output on
// each falling edge. Literal expectations from the test plan are checked
// in the stimulus process as well.
// -----------------------------------------------------------------------------
module tb_return_addr_stack;

  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int PW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic [1:0]    jump;
  logic [1:0]    memtoreg;
  logic          memwrite;
  logic          memread;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] top_addr;
  logic          empty;
  logic          full;
  logic [PW:0]   count;
  logic          fault;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  return_addr_stack #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) dut (
    .Clock    (clk),
    .Reset    (rst_n),
    .Stall    (stall),
    .Jump     (jump),
    .MemtoReg (memtoreg),
    .MemWrite (memwrite),
    .MemRead  (memread),
    .PushAddr (push_addr),
    .TopAddr  (top_addr),
    .Empty    (empty),
    .Full     (full),
    .Count    (count),
    .Fault    (fault),
    .Overflow (overflow),
    .Underflow(underflow)
  );

  // ---------------- behavioural model ----------------
  logic [AW-1:0] mq[$];
  bit            m_fault, m_ovf, m_und, m_frozen;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin
    bit p, q;
    p = memwrite && (memtoreg == 2'b10) && !stall;
    q = memread  && (jump     == 2'b10) && !stall;
    if (!rst_n) begin
      mq.delete();
      m_fault  = 1'b0;
      m_ovf    = 1'b0;
      m_und    = 1'b0;
      m_frozen = 1'b0;
      m_valid  = 1'b1;
    end else if (!m_frozen) begin
      if (p && q) begin
        if (mq.size() > 0) mq[mq.size()-1] = push_addr;
        else mq.push_back(push_addr);
      end else if (p) begin
        if (mq.size() == DEPTH) begin
`ifdef RAS_WRAP_OVERFLOW_EN
          void'(mq.pop_front());
          mq.push_back(push_addr);
          m_ovf = 1'b1;
`else
          m_ovf    = 1'b1;
          m_fault  = 1'b1;
          m_frozen = 1'b1;
`endif
        end else begin
          mq.push_back(push_addr);
        end
      end else if (q) begin
        if (mq.size() == 0) begin
          m_und    = 1'b1;
          m_fault  = 1'b1;
          m_frozen = 1'b1;
        end else begin
          void'(mq.pop_back());
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [AW-1:0] mtop;
      int            n;
      n    = mq.size();
      mtop = (n == 0) ? '0 : mq[n-1];
      cmp("model_top",   top_addr,          mtop);
      cmp("model_count", AW'(count),        AW'(n));
      cmp("model_empty", AW'(empty),        AW'(n == 0));
      cmp("model_full",  AW'(full),         AW'(n == DEPTH));
      cmp("model_fault", AW'(fault),        AW'(m_fault));
      cmp("model_ovf",   AW'(overflow),     AW'(m_ovf));
      cmp("model_und",   AW'(underflow),    AW'(m_und));
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle of request; returns at the following falling edge,
  // where outputs reflect the rising edge that consumed the request.
  task automatic op(input bit psh, input bit pp, input logic [AW-1:0] a,
                    input bit stl, input bit rn);
    memwrite  = psh;
    memtoreg  = psh ? 2'b10 : 2'b00;
    memread   = pp;
    jump      = pp ? 2'b10 : 2'b00;
    push_addr = a;
    stall     = stl;
    rst_n     = rn;
    @(negedge clk);
    memwrite = 1'b0;
    memread  = 1'b0;
    memtoreg = 2'b00;
    jump     = 2'b00;
    stall    = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic push(input logic [AW-1:0] a); op(1, 0, a, 0, 1); endtask
  task automatic pop();                        op(0, 1, 0, 0, 1); endtask
  task automatic rst();                        op(0, 0, 0, 0, 0); endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; jump = 2'b00; memtoreg = 2'b00;
    memwrite = 1'b0; memread = 1'b0; push_addr = '0;
    @(negedge clk);
    rst();

    // Reset state
    cmp("rst_count", AW'(count), 0);
    cmp("rst_empty", AW'(empty), 1);
    cmp("rst_full",  AW'(full),  0);
    cmp("rst_top",   top_addr,   0);
    cmp("rst_fault", AW'(fault), 0);

    // Single JAL
    push(32'h40);
    cmp("jal_count", AW'(count), 1);
    cmp("jal_top",   top_addr,   32'h40);
    cmp("jal_empty", AW'(empty), 0);

    // LIFO order, top visible during the JS cycle
    rst();
    push(32'h10); push(32'h20); push(32'h30);
    cmp("js1_top", top_addr, 32'h30); pop();
    cmp("js2_top", top_addr, 32'h20); pop();
    cmp("js3_top", top_addr, 32'h10); pop();
    cmp("lifo_count", AW'(count), 0);
    cmp("lifo_empty", AW'(empty), 1);
    cmp("lifo_top",   top_addr,   0);

    // Underflow freezes the stack until reset
    pop();
    cmp("und_flag",  AW'(underflow), 1);
    cmp("und_fault", AW'(fault),     1);
    push(32'h50);
    cmp("und_frozen_count", AW'(count), 0);
    rst();
    cmp("und_clr_und",   AW'(underflow), 0);
    cmp("und_clr_fault", AW'(fault),     0);

    // Fill, then push while full
    for (int i = 0; i < DEPTH; i++) push(32'h100 + 4 * i);
    cmp("fill_full", AW'(full), 1);
    cmp("fill_top",  top_addr,  32'h13C);
    push(32'h200);
    cmp("ovf_flag", AW'(overflow), 1);
`ifdef RAS_WRAP_OVERFLOW_EN
    cmp("wrap_top",   top_addr,    32'h200);
    cmp("wrap_count", AW'(count),  16);
    cmp("wrap_fault", AW'(fault),  0);
    cmp("wrap_pop0",  top_addr,    32'h200); pop();
    for (int i = 15; i >= 1; i--) begin
      cmp("wrap_popn", top_addr, 32'h100 + 4 * i);
      pop();
    end
    cmp("wrap_drained", AW'(count), 0);
`else
    cmp("ovf_full",  AW'(full),  1);
    cmp("ovf_fault", AW'(fault), 1);
    cmp("ovf_top",   top_addr,   32'h13C);
    pop();
    cmp("ovf_frozen_count", AW'(count), 16);
`endif

    // Stall holds everything
    rst();
    op(1, 0, 32'h77, 1, 1);
    cmp("stall_count", AW'(count), 0);
    cmp("stall_top",   top_addr,   0);
    push(32'h77);
    cmp("unstall_count", AW'(count), 1);
    cmp("unstall_top",   top_addr,   32'h77);
    op(0, 1, 0, 1, 1);
    cmp("stall_pop_count", AW'(count), 1);

    // Non-JAL encoding on MemtoReg must not push
    memwrite = 1'b1; memtoreg = 2'b01; push_addr = 32'hDEAD;
    @(negedge clk);
    memwrite = 1'b0; memtoreg = 2'b00;
    cmp("decode_count", AW'(count), 1);

    // Simultaneous push/pop replaces the top
    rst();
    push(32'h10); push(32'h20);
    op(1, 1, 32'h99, 0, 1);
    cmp("repl_count", AW'(count), 2);
    cmp("repl_top",   top_addr,   32'h99);
    pop();
    cmp("repl_older", top_addr,   32'h10);

    // Reset during a pop discards it
    op(0, 1, 0, 0, 0);
    cmp("rstpop_count", AW'(count),     0);
    cmp("rstpop_und",   AW'(underflow), 0);

    // Push+pop on empty acts as a push, no underflow
    op(1, 1, 32'h5A, 0, 1);
    cmp("pp_empty_count", AW'(count),     1);
    cmp("pp_empty_top",   top_addr,       32'h5A);
    cmp("pp_empty_und",   AW'(underflow), 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack serving the stack-based call/return scheme driven by the control unit.
- Responder side of the JAL/JS stack interface: consumes the decoded stack signals (Jump, MemtoReg, MemWrite, MemRead) and the return address.
- JAL pushes PC+4; JS pops and supplies the jump target.
- Sits beside the register file and PC-select logic in the datapath.

Parameters:
- DEPTH, 16, number of stack entries (power of two, >=2).
- AW, 32, return-address width in bits.
- PW, 4, pointer width; equals log2(DEPTH).

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  synchronous, active-low; sampled on the rising edge of Clock.
- Stall  in  1  1 = hold all state; push and pop are ignored.
- Jump  in  2  from control unit; 2'b10 marks JS.
- MemtoReg  in  2  from control unit; 2'b10 marks JAL.
- MemWrite  in  1  from control unit.
- MemRead  in  1  from control unit.
- PushAddr  in  AW  return address (PC+4) to push.
- TopAddr  out  AW  current top entry, combinational; the JS target.
- Empty  out  1  count == 0.
- Full  out  1  count == DEPTH.
- Count  out  PW+1  number of valid entries.
- Fault  out  1  sticky error indicator.
- Overflow  out  1  sticky; a push was attempted while Full.
- Underflow  out  1  sticky; a pop was attempted while Empty.

Behaviour:
- Request decode:
  - push_req = MemWrite & (MemtoReg == 2'b10) & ~Stall.
  - pop_req = MemRead & (Jump == 2'b10) & ~Stall.
- Reset (Reset == 0 at a rising edge):
  - sp = 0, Count = 0, Empty = 1, Full = 0.
  - Fault = 0, Overflow = 0, Underflow = 0.
  - State = NORMAL.
  - Entry storage is not cleared.
  - Reset wins over any simultaneous request.
- TopAddr:
  - Equals mem[sp-1] (modulo DEPTH) whenever Count > 0.
  - Equals 0 when Empty.
  - Valid in the same cycle as the JS decode, so the jump target costs zero latency.
- Push, NORMAL state and not Full:
  - mem[sp] <= PushAddr; sp <= sp+1; Count <= Count+1 at the edge.
  - TopAddr reflects PushAddr from the next cycle.
- Pop, NORMAL state and not Empty:
  - sp <= sp-1; Count <= Count-1 at the edge.
  - TopAddr during the request cycle is the popped value.
- Push and pop in the same cycle (not produced by legal decode, but defined):
  - If Count > 0: replace the top, mem[sp-1] <= PushAddr; sp and Count unchanged.
  - If Empty: treat as a push only; Underflow is not set.
- Pointer arithmetic: sp wraps modulo DEPTH, using PW bits.
- State machine, 2 states:
  - NORMAL: push/pop applied as above.
    - Push while Full: Overflow <= 1, Fault <= 1, go to FAULT; stack unchanged.
    - Pop while Empty: Underflow <= 1, Fault <= 1, go to FAULT; stack unchanged.
  - FAULT: all push/pop requests are ignored; TopAddr, Count, Empty and Full stay frozen.
    - Exit only via Reset.
- Stall = 1: no state change, including no fault detection. Outputs keep their values.
- Reset asserted mid-sequence (e.g. during a pop cycle): the request is discarded and the stack becomes empty.

Optional Feature:
- Macro: RAS_WRAP_OVERFLOW_EN.
- Defined:
  - A push while Full overwrites the oldest entry: mem[sp] <= PushAddr, sp <= sp+1, Count stays DEPTH.
  - Overflow is set (sticky), but Fault is not set and the state stays NORMAL.
  - Underflow handling is unchanged.
- Undefined: push while Full enters FAULT, as specified above.

Test Plan:
- Reset then JAL with PushAddr=0x0000_0040 -> next cycle Count=1, TopAddr=0x40, Empty=0.
- Push 0x10, 0x20, 0x30, then JS three times -> TopAddr shows 0x30, 0x20, 0x10 in the respective JS cycles; final Count=0, Empty=1, TopAddr=0.
- JS on an empty stack -> Underflow=1, Fault=1; a subsequent JAL of 0x50 is ignored, Count stays 0; Reset low for one edge clears all flags.
- 16 pushes of 0x100+4*i then a 17th push of 0x200:
  - Without macro: Full=1, Overflow=1, Fault=1, TopAddr=0x13C.
  - With RAS_WRAP_OVERFLOW_EN: TopAddr=0x200, Count=16, Fault=0; 16 pops return 0x200, 0x13C ... 0x104.
- Stall=1 during JAL of 0x77 -> Count and TopAddr unchanged; the same request repeated with Stall=0 pushes 0x77.
- Count=2 (top 0x20), push and pop asserted together with PushAddr=0x99 -> Count=2, TopAddr=0x99; the following pop exposes the older entry.
